// File: rtl/plab4_net_eject_sep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : plab4_net_eject_sep_pkg
// Purpose  : Shared definitions for the ring-net ejection stage. Provides
//            the net message layout helpers (total width and field offsets
//            for a {dest, src, opaque, payload} control message, where
//            p = payload bits, o = opaque bits and s = src/dest bits) and
//            the domain encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package plab4_net_eject_sep_pkg;

    // Domain tag carried alongside each delivered message
    localparam logic DOMAIN_D1 = 1'b0;
    localparam logic DOMAIN_D2 = 1'b1;

    // Total control message width: {dest, src, opaque, payload}
    function automatic int net_msg_nbits(input int p, input int o, input int s);
        return p + o + 2 * s;
    endfunction

    // Field LSB offsets; dest occupies the most significant bits
    function automatic int net_msg_payload_lsb(input int p, input int o, input int s);
        return 0;
    endfunction

    function automatic int net_msg_opaque_lsb(input int p, input int o, input int s);
        return p;
    endfunction

    function automatic int net_msg_src_lsb(input int p, input int o, input int s);
        return p + o;
    endfunction

    function automatic int net_msg_dest_lsb(input int p, input int o, input int s);
        return p + o + s;
    endfunction

    function automatic int net_msg_dest_msb(input int p, input int o, input int s);
        return p + o + 2 * s - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/plab4_net_eject_sep_if.sv
`default_nettype none
// ============================================================================
// Module   : plab4_net_eject_sep_if
// Purpose  : Bundles the ejection stage's terminal-side input handshake, the
//            two per-domain output handshakes and the misroute counter.
// Modports : master - ring terminal / consumers side (drives in_*, out_rdy_*)
//            slave  - ejection stage side (drives in_rdy, out_val_*, out_msg_*,
//                     misroute_cnt)
// Revision : 1.0 - initial release
// ============================================================================
interface plab4_net_eject_sep_if #(
    parameter int p_payload_cnbits = 32,
    parameter int p_payload_dnbits = 32,
    parameter int p_opaque_nbits   = 3,
    parameter int p_srcdest_nbits  = 3
);
    localparam int c_msg_nbits = plab4_net_eject_sep_pkg::net_msg_nbits(
        p_payload_cnbits, p_opaque_nbits, p_srcdest_nbits);

    // Terminal side
    logic                        in_val;
    logic                        in_rdy;
    logic                        in_domain;
    logic [c_msg_nbits-1:0]      in_msg_control;
    logic [p_payload_dnbits-1:0] in_msg_data;

    // Domain 0 (d1) consumer side
    logic                        out_val_d1;
    logic                        out_rdy_d1;
    logic [c_msg_nbits-1:0]      out_msg_control_d1;
    logic [p_payload_dnbits-1:0] out_msg_data_d1;

    // Domain 1 (d2) consumer side
    logic                        out_val_d2;
    logic                        out_rdy_d2;
    logic [c_msg_nbits-1:0]      out_msg_control_d2;
    logic [p_payload_dnbits-1:0] out_msg_data_d2;

    logic [7:0]                  misroute_cnt;

    modport master (
        output in_val, in_domain, in_msg_control, in_msg_data,
        output out_rdy_d1, out_rdy_d2,
        input  in_rdy,
        input  out_val_d1, out_msg_control_d1, out_msg_data_d1,
        input  out_val_d2, out_msg_control_d2, out_msg_data_d2,
        input  misroute_cnt
    );

    modport slave (
        input  in_val, in_domain, in_msg_control, in_msg_data,
        input  out_rdy_d1, out_rdy_d2,
        output in_rdy,
        output out_val_d1, out_msg_control_d1, out_msg_data_d1,
        output out_val_d2, out_msg_control_d2, out_msg_data_d2,
        output misroute_cnt
    );

endinterface
`default_nettype wire

// File: rtl/plab4_net_eject_queue.sv
`default_nettype none
// ============================================================================
// Module   : plab4_net_eject_queue
// Purpose  : Single-domain FIFO for the ejection stage. No bypass paths, so
//            an entry is visible one cycle after it is written. A dequeued
//            entry is cleared to zero on the same edge, so the outputs read
//            zero whenever the queue is empty.
// Ports    : clk, reset (async, active-low)
//            enq_val/enq_ctrl/enq_data - write request (ignored when full)
//            full                      - count has reached p_num_entries
//            deq_val/deq_rdy           - output handshake
//            deq_ctrl/deq_data         - entry at head
// Revision : 1.0 - initial release
// ============================================================================
module plab4_net_eject_queue #(
    parameter int p_ctrl_nbits  = 41,
    parameter int p_data_nbits  = 32,
    parameter int p_num_entries = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enq_val,
    input  logic [p_ctrl_nbits-1:0] enq_ctrl,
    input  logic [p_data_nbits-1:0] enq_data,
    output logic                    full,
    output logic                    deq_val,
    input  logic                    deq_rdy,
    output logic [p_ctrl_nbits-1:0] deq_ctrl,
    output logic [p_data_nbits-1:0] deq_data
);

    localparam int c_ptr_nbits = $clog2(p_num_entries);
    localparam int c_cnt_nbits = c_ptr_nbits + 1;

    localparam logic [c_ptr_nbits-1:0] c_ptr_one  = c_ptr_nbits'(1);
    localparam logic [c_cnt_nbits-1:0] c_cnt_one  = c_cnt_nbits'(1);
    localparam logic [c_cnt_nbits-1:0] c_cnt_full = c_cnt_nbits'(p_num_entries);

    logic [p_ctrl_nbits-1:0] r_ctrl [p_num_entries];
    logic [p_data_nbits-1:0] r_data [p_num_entries];
    logic [c_ptr_nbits-1:0]  r_head;
    logic [c_ptr_nbits-1:0]  r_tail;
    logic [c_cnt_nbits-1:0]  r_count;

    logic w_enq;
    logic w_deq;

    assign full     = (r_count == c_cnt_full);
    assign deq_val  = (r_count != '0);
    assign deq_ctrl = r_ctrl[r_head];
    assign deq_data = r_data[r_head];

    // Enqueue is refused when full even if a dequeue happens on the same
    // edge. That guarantees head != tail whenever both fire, so the write
    // and the scrub below never target the same entry.
    assign w_enq = enq_val & ~full;
    assign w_deq = deq_val & deq_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < p_num_entries; i++) begin
                r_ctrl[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_enq) begin
                r_ctrl[r_tail] <= enq_ctrl;
                r_data[r_tail] <= enq_data;
                r_tail         <= r_tail + c_ptr_one;
            end
            if (w_deq) begin
                r_ctrl[r_head] <= '0;
                r_data[r_head] <= '0;
                r_head         <= r_head + c_ptr_one;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/plab4_net_eject_sep.sv
`default_nettype none
// ============================================================================
// Module   : plab4_net_eject_sep
// Purpose  : Ejection stage behind one ring-net terminal. Steers each
//            delivered message into a private queue for its domain so a
//            stalled consumer in one domain never blocks the other, and
//            drops (while still accepting) messages whose dest field does
//            not match this terminal, counting them in misroute_cnt.
// Ports    : clk, reset (async, active-low)
//            ifc (slave) - in_* terminal handshake, out_*_d1 / out_*_d2
//                          domain handshakes, misroute_cnt
// Revision : 1.0 - initial release
// ============================================================================
module plab4_net_eject_sep
    import plab4_net_eject_sep_pkg::*;
#(
    parameter int p_payload_cnbits = 32,
    parameter int p_payload_dnbits = 32,
    parameter int p_opaque_nbits   = 3,
    parameter int p_srcdest_nbits  = 3,
    parameter int p_router_id      = 0,
    parameter int p_num_entries    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    plab4_net_eject_sep_if.slave  ifc
);

    localparam int c_msg_nbits = net_msg_nbits(p_payload_cnbits, p_opaque_nbits,
                                               p_srcdest_nbits);
    localparam int c_dest_msb  = net_msg_dest_msb(p_payload_cnbits, p_opaque_nbits,
                                                  p_srcdest_nbits);
    localparam int c_dest_lsb  = net_msg_dest_lsb(p_payload_cnbits, p_opaque_nbits,
                                                  p_srcdest_nbits);

    localparam logic [p_srcdest_nbits-1:0] c_router_id = p_srcdest_nbits'(p_router_id);
    localparam logic [7:0]                 c_cnt_max   = 8'hFF;

    logic       w_full_d1;
    logic       w_full_d2;
    logic       w_dest_ok;
    logic       w_accept;
    logic       w_enq_d1;
    logic       w_enq_d2;
    logic [7:0] r_misroute_cnt;

    // Readiness depends only on the addressed queue, never on in_val
    assign ifc.in_rdy = (ifc.in_domain == DOMAIN_D2) ? ~w_full_d2 : ~w_full_d1;

    assign w_dest_ok = (ifc.in_msg_control[c_dest_msb:c_dest_lsb] == c_router_id);
    assign w_accept  = ifc.in_val & ifc.in_rdy;
    assign w_enq_d1  = w_accept & w_dest_ok & (ifc.in_domain == DOMAIN_D1);
    assign w_enq_d2  = w_accept & w_dest_ok & (ifc.in_domain == DOMAIN_D2);

    plab4_net_eject_queue #(
        .p_ctrl_nbits  (c_msg_nbits),
        .p_data_nbits  (p_payload_dnbits),
        .p_num_entries (p_num_entries)
    ) u_queue_d1 (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (w_enq_d1),
        .enq_ctrl (ifc.in_msg_control),
        .enq_data (ifc.in_msg_data),
        .full     (w_full_d1),
        .deq_val  (ifc.out_val_d1),
        .deq_rdy  (ifc.out_rdy_d1),
        .deq_ctrl (ifc.out_msg_control_d1),
        .deq_data (ifc.out_msg_data_d1)
    );

    plab4_net_eject_queue #(
        .p_ctrl_nbits  (c_msg_nbits),
        .p_data_nbits  (p_payload_dnbits),
        .p_num_entries (p_num_entries)
    ) u_queue_d2 (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (w_enq_d2),
        .enq_ctrl (ifc.in_msg_control),
        .enq_data (ifc.in_msg_data),
        .full     (w_full_d2),
        .deq_val  (ifc.out_val_d2),
        .deq_rdy  (ifc.out_rdy_d2),
        .deq_ctrl (ifc.out_msg_control_d2),
        .deq_data (ifc.out_msg_data_d2)
    );

    // A misrouted message completes its handshake but is discarded here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misroute_cnt <= '0;
        end else if (w_accept && !w_dest_ok && (r_misroute_cnt != c_cnt_max)) begin
            r_misroute_cnt <= r_misroute_cnt + 8'd1;
        end
    end

    assign ifc.misroute_cnt = r_misroute_cnt;

endmodule
`default_nettype wire

// File: tb/tb_plab4_net_eject_sep.sv
`default_nettype none
// ============================================================================
// Module   : tb_plab4_net_eject_sep
// Purpose  : Directed self-checking bench for plab4_net_eject_sep
//            (p_router_id = 0, p_num_entries = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_plab4_net_eject_sep;

    localparam int c_cn = 32;
    localparam int c_dn = 32;
    localparam int c_on = 3;
    localparam int c_sn = 3;
    localparam int c_m  = c_cn + c_on + 2 * c_sn;

    logic clk;
    logic reset;

    int n_checks;
    int n_fail;

    plab4_net_eject_sep_if #(
        .p_payload_cnbits (c_cn),
        .p_payload_dnbits (c_dn),
        .p_opaque_nbits   (c_on),
        .p_srcdest_nbits  (c_sn)
    ) ifc ();

    plab4_net_eject_sep #(
        .p_payload_cnbits (c_cn),
        .p_payload_dnbits (c_dn),
        .p_opaque_nbits   (c_on),
        .p_srcdest_nbits  (c_sn),
        .p_router_id      (0),
        .p_num_entries    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_m-1:0] mk_ctrl(input logic [2:0] dest, input logic [2:0] src,
                                               input logic [2:0] opq, input logic [31:0] pl);
        return {dest, src, opq, pl};
    endfunction

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic val, input logic dom, input logic [c_m-1:0] ctrl,
                         input logic [31:0] data);
        ifc.in_val         = val;
        ifc.in_domain      = dom;
        ifc.in_msg_control = ctrl;
        ifc.in_msg_data    = data;
    endtask

    logic [c_m-1:0] m_a, m_b, m_c, m_d, m_e, m_f, m_x, m_bad;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        ifc.out_rdy_d1 = 1'b0;
        ifc.out_rdy_d2 = 1'b0;
        drive(1'b0, 1'b0, '0, '0);

        m_x = mk_ctrl(3'd0, 3'd1, 3'd2, 32'hDEADBEEF);
        m_a = mk_ctrl(3'd0, 3'd2, 3'd1, 32'hA0A0A0A0);
        m_b = mk_ctrl(3'd0, 3'd3, 3'd2, 32'hB1B1B1B1);
        m_c = mk_ctrl(3'd0, 3'd4, 3'd3, 32'hC2C2C2C2);
        m_d = mk_ctrl(3'd0, 3'd5, 3'd4, 32'h0000D0D0);
        m_e = mk_ctrl(3'd0, 3'd6, 3'd5, 32'h0000E0E0);
        m_f = mk_ctrl(3'd0, 3'd7, 3'd6, 32'h0000F0F0);
        m_bad = mk_ctrl(3'd5, 3'd1, 3'd0, 32'h12345678);

        // ---------------- reset then idle ----------------
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_eq("rst_rdy_d0", ifc.in_rdy, 1'b1);
        ifc.in_domain = 1'b1;
        #1;
        check_eq("rst_rdy_d1", ifc.in_rdy, 1'b1);
        check_eq("rst_val_d1", ifc.out_val_d1, 1'b0);
        check_eq("rst_val_d2", ifc.out_val_d2, 1'b0);
        check_eq("rst_mis",    ifc.misroute_cnt, 8'd0);
        check_eq("rst_ctl_d1", ifc.out_msg_control_d1, '0);
        check_eq("rst_dat_d2", ifc.out_msg_data_d2, '0);

        // ---------------- single delivery ----------------
        drive(1'b1, 1'b1, m_x, 32'hDEADBEEF);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        check_eq("single_val_d2", ifc.out_val_d2, 1'b1);
        check_eq("single_dat_d2", ifc.out_msg_data_d2, 32'hDEADBEEF);
        check_eq("single_ctl_d2", ifc.out_msg_control_d2, m_x);
        check_eq("single_val_d1", ifc.out_val_d1, 1'b0);
        ifc.out_rdy_d2 = 1'b1;
        tick();
        ifc.out_rdy_d2 = 1'b0;
        check_eq("single_deq_val", ifc.out_val_d2, 1'b0);
        check_eq("single_deq_dat", ifc.out_msg_data_d2, '0);
        check_eq("single_deq_ctl", ifc.out_msg_control_d2, '0);

        // ---------------- domain isolation ----------------
        drive(1'b1, 1'b1, m_a, 32'h1);
        #1;
        check_eq("iso_rdy_a", ifc.in_rdy, 1'b1);
        tick();
        drive(1'b1, 1'b1, m_b, 32'h2);
        #1;
        check_eq("iso_rdy_b", ifc.in_rdy, 1'b1);
        tick();
        drive(1'b1, 1'b1, m_c, 32'h3);
        #1;
        check_eq("iso_rdy_full", ifc.in_rdy, 1'b0);
        tick();
        check_eq("iso_head_d2", ifc.out_msg_control_d2, m_a);
        drive(1'b1, 1'b0, m_c, 32'h3);
        #1;
        check_eq("iso_rdy_d0", ifc.in_rdy, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        check_eq("iso_val_d1", ifc.out_val_d1, 1'b1);
        check_eq("iso_ctl_d1", ifc.out_msg_control_d1, m_c);
        check_eq("iso_dat_d1", ifc.out_msg_data_d1, 32'h3);
        check_eq("iso_still_a", ifc.out_msg_data_d2, 32'h1);
        ifc.out_rdy_d1 = 1'b1;
        ifc.out_rdy_d2 = 1'b1;
        tick();
        check_eq("iso_d2_b", ifc.out_msg_control_d2, m_b);
        check_eq("iso_d1_empty", ifc.out_val_d1, 1'b0);
        ifc.out_rdy_d1 = 1'b0;
        tick();
        ifc.out_rdy_d2 = 1'b0;
        check_eq("iso_d2_empty", ifc.out_val_d2, 1'b0);
        check_eq("iso_d2_scrub", ifc.out_msg_data_d2, '0);

        // ---------------- full with simultaneous dequeue ----------------
        drive(1'b1, 1'b0, m_d, 32'hD);
        tick();
        drive(1'b1, 1'b0, m_e, 32'hE);
        tick();
        drive(1'b1, 1'b0, m_f, 32'hF);
        ifc.out_rdy_d1 = 1'b1;
        #1;
        check_eq("full_rdy", ifc.in_rdy, 1'b0);
        check_eq("full_head_d", ifc.out_msg_control_d1, m_d);
        tick();
        ifc.out_rdy_d1 = 1'b0;
        #1;
        check_eq("full_head_e", ifc.out_msg_control_d1, m_e);
        check_eq("full_rdy_after", ifc.in_rdy, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        check_eq("full_hold_e", ifc.out_msg_data_d1, 32'hE);
        ifc.out_rdy_d1 = 1'b1;
        tick();
        check_eq("wrap_head_f", ifc.out_msg_control_d1, m_f);
        check_eq("wrap_dat_f", ifc.out_msg_data_d1, 32'hF);
        tick();
        ifc.out_rdy_d1 = 1'b0;
        check_eq("wrap_empty", ifc.out_val_d1, 1'b0);

        // ---------------- misroute saturation ----------------
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, i[0], m_bad, 32'h55);
            #1;
            check_eq("mis_rdy", ifc.in_rdy, 1'b1);
            tick();
            check_eq("mis_cnt", ifc.misroute_cnt, (i + 1 > 255) ? 64'd255 : 64'(i + 1));
        end
        drive(1'b0, 1'b0, '0, '0);
        check_eq("mis_val_d1", ifc.out_val_d1, 1'b0);
        check_eq("mis_val_d2", ifc.out_val_d2, 1'b0);

        // ---------------- async reset mid-stream ----------------
        drive(1'b1, 1'b0, m_a, 32'h11);
        tick();
        drive(1'b1, 1'b0, m_b, 32'h12);
        tick();
        drive(1'b1, 1'b1, m_c, 32'h21);
        tick();
        drive(1'b1, 1'b1, m_d, 32'h22);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        check_eq("ar_pre_val_d1", ifc.out_val_d1, 1'b1);
        check_eq("ar_pre_val_d2", ifc.out_val_d2, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        check_eq("ar_val_d1", ifc.out_val_d1, 1'b0);
        check_eq("ar_val_d2", ifc.out_val_d2, 1'b0);
        check_eq("ar_dat_d1", ifc.out_msg_data_d1, '0);
        check_eq("ar_ctl_d2", ifc.out_msg_control_d2, '0);
        check_eq("ar_mis",    ifc.misroute_cnt, 8'd0);
        tick();
        reset = 1'b1;
        tick();
        check_eq("ar_post_val_d1", ifc.out_val_d1, 1'b0);
        check_eq("ar_post_val_d2", ifc.out_val_d2, 1'b0);
        ifc.in_domain = 1'b1;
        #1;
        check_eq("ar_post_rdy", ifc.in_rdy, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
